// File: rtl/wb_stage.sv
// Writeback stage: tracks outstanding dmem accesses, aligns loads, drives regfile write and RVFI commit.
// Latency: regfile/RVFI outputs are combinational from in_*; load data is registered from the response cycle.
// Backpressure: mem_stall is raised while an access is outstanding and its response has not yet arrived.
module wb_stage #(
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dmem_req,
    input  logic               dmem_resp,
    input  logic [31:0]        dmem_rdata,
    output logic               mem_stall,
    input  logic               in_valid,
    input  logic [4:0]         in_rd_addr,
    input  logic [31:0]        in_func_out,
    input  logic               in_mem_read,
    input  logic [2:0]         in_mem_funct3,
    input  logic               in_regf_we,
    input  logic [31:0]        in_pc,
    output logic               regf_we,
    output logic [4:0]         regf_waddr,
    output logic [31:0]        regf_wdata,
    output logic               rvfi_valid,
    output logic [ORDER_W-1:0] rvfi_order,
    output logic [4:0]         rvfi_rd_addr,
    output logic [31:0]        rvfi_rd_wdata,
    output logic [31:0]        rvfi_mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [31:0]        rdata_q;
    logic [ORDER_W-1:0] order_q;
    logic               resp_accept;
    logic [1:0]         off;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_data;
    logic               unused_pc;

    // PC is carried for RVFI completeness but not reported by this stage.
    assign unused_pc = ^in_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response is only meaningful in WAIT; in IDLE it is spurious and ignored.
    always_comb begin
        state_d     = state_q;
        mem_stall   = 1'b0;
        resp_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_req) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_stall = !dmem_resp;
                if (dmem_resp) begin
                    resp_accept = 1'b1;
                    state_d     = dmem_req ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (resp_accept) begin
            rdata_q <= dmem_rdata;
        end
    end

    assign off     = in_func_out[1:0];
    assign ld_byte = rdata_q[{off, 3'b000} +: 8];
    assign ld_half = off[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        ld_data = '0;
        case (in_mem_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = rdata_q;
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = '0;
        endcase
    end

    assign regf_we    = in_valid && in_regf_we && (in_rd_addr != 5'd0);
    assign regf_waddr = in_rd_addr;
    assign regf_wdata = in_mem_read ? ld_data : in_func_out;

    assign rvfi_valid = in_valid && !mem_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            order_q <= '0;
        end else if (rvfi_valid) begin
            order_q <= order_q + ORDER_W'(1);
        end
    end

    assign rvfi_order     = order_q;
    assign rvfi_rd_addr   = regf_we ? in_rd_addr : 5'd0;
    assign rvfi_rd_wdata  = regf_we ? regf_wdata : 32'd0;
    assign rvfi_mem_rdata = rdata_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the rv32imc pipeline, directly downstream of the data memory stage.
- Tracks each outstanding data-memory access and generates mem_stall until the response arrives.
- Captures and holds load response data across stalls, then aligns and sign/zero-extends it.
- Selects the writeback value, drives the register-file write port and forwarding bus, and emits the RVFI commit record with a retirement order counter.

Parameters:
ORDER_W, 64, width of RVFI retirement order counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
dmem_req  input  1  memory stage issued an access this cycle (rmask or wmask nonzero)
dmem_resp  input  1  data memory response valid (read data or write ack)
dmem_rdata  input  32  word-aligned read data, valid with dmem_resp
mem_stall  output  1  stall to memory stage and everything upstream
in_valid  input  1  memory-stage pipeline register holds a real instruction
in_rd_addr  input  5  destination register
in_func_out  input  32  ALU/address result
in_mem_read  input  1  instruction is a load
in_mem_funct3  input  3  load type: lb=000, lh=001, lw=010, lbu=100, lhu=101
in_regf_we  input  1  instruction writes rd
in_pc  input  32  instruction PC (RVFI)
regf_we  output  1  register-file write enable
regf_waddr  output  5  register-file write address
regf_wdata  output  32  register-file write data; also forwarding bus
rvfi_valid  output  1  commit valid
rvfi_order  output  ORDER_W  retirement index
rvfi_rd_addr  output  5  committed rd (0 if no write)
rvfi_rd_wdata  output  32  committed rd data (0 if no write)
rvfi_mem_rdata  output  32  raw captured memory word

Behaviour:
Access tracker FSM (IDLE, WAIT):
- IDLE: dmem_req -> WAIT. A response is never accepted in the request cycle.
- WAIT: mem_stall = !dmem_resp.
  - dmem_resp && !dmem_req -> IDLE.
  - dmem_resp && dmem_req -> remain WAIT (back-to-back access).
  - dmem_resp in IDLE is ignored (spurious). No counting, no capture.
- mem_stall is combinational from state and dmem_resp. It is 0 in IDLE.
- Latency: a single access costs exactly the number of cycles until dmem_resp. A response in the cycle after the request gives zero stall cycles.

Load data capture:
- rdata_q <= dmem_rdata on any accepted response (state WAIT && dmem_resp). Otherwise it holds.
- Consumers use rdata_q in the cycle after the response, when the load has advanced into in_*.

Alignment and extension (off = in_func_out[1:0]):
- lb/lbu: byte rdata_q[8*off +: 8], sign- or zero-extended to 32.
- lh/lhu: half rdata_q[16*off[1] +: 16], sign- or zero-extended. off[0] is ignored (misaligned access is not supported).
- lw: rdata_q unchanged.
- Undefined funct3: result is 0.

Writeback:
- regf_wdata = in_mem_read ? aligned load : in_func_out.
- regf_we = in_valid && in_regf_we && (in_rd_addr != 0).
- regf_waddr = in_rd_addr.
- All three are combinational; register-file write occurs at the clk edge.

RVFI:
- rvfi_valid = in_valid && !mem_stall.
- rvfi_rd_addr and rvfi_rd_wdata are zero when regf_we = 0.
- rvfi_order is a register: reset 0, incremented by 1 on each cycle rvfi_valid = 1. It is presented before the increment, so the first commit reports 0. It wraps modulo 2^ORDER_W.

Reset (rst at clk edge, any cycle including mid-WAIT):
- state -> IDLE, rdata_q -> 0, rvfi_order -> 0.
- Any in-flight response is dropped.
- Outputs after reset with in_* = 0: mem_stall=0, regf_we=0, regf_wdata=0, rvfi_valid=0.

Test Plan:
- lw at func_out 0x1000; dmem_req pulse; dmem_resp 3 cycles later with rdata 0xDEADBEEF -> mem_stall high for 2 cycles; next cycle regf_we=1 and regf_wdata=0xDEADBEEF; rvfi_order=0.
- rdata 0x80FF7F01: lb off=3 -> 0xFFFFFF80; lbu off=3 -> 0x00000080; lh off=2 -> 0xFFFF80FF; lhu off=0 -> 0x00007F01.
- ALU instruction with rd=x0 and in_regf_we=1 -> regf_we=0; rvfi_valid=1 with rvfi_rd_addr=0 and rvfi_rd_wdata=0; order increments.
- Back-to-back accesses: second dmem_req in the response cycle of the first -> FSM stays WAIT; mem_stall=1 the next cycle until the second response; each rdata is captured separately.
- rst asserted in WAIT before response; response arrives the cycle after -> state IDLE, response ignored, rdata_q=0, mem_stall=0.
- Spurious dmem_resp in IDLE with rdata 0x12345678 -> rdata_q unchanged, mem_stall stays 0.
